// File: rtl/vga_fetch_arbiter.sv
// Shares a single-port pixel RAM between linear display prefetch (into a pixel FIFO) and host writes.
// Optional: define VGA_FETCH_UNDERRUN_CNT_EN to add a saturating underrun_cnt output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no display reads, host always ready
// PREFILL | read every cycle until FIFO plus in-flight read is full, host blocked
// RUN     | display reads pre-empt the host below LOW_WATER, host otherwise
// DONE    | whole frame fetched, host always ready
module vga_fetch_arbiter #(
    parameter int ACTIVE_WIDTH  = 640,
    parameter int ACTIVE_HEIGHT = 480,
    parameter int ADDR_W        = 19,
    parameter int DATA_W        = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int LOW_WATER     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              de,
    output logic [DATA_W-1:0] pix_data,
    output logic              underrun,
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt,
`endif
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int TOTAL = ACTIVE_WIDTH * ACTIVE_HEIGHT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(TOTAL);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  LOW_C     = CNT_W'(LOW_WATER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  occ, level;
    logic [ADDR_W-1:0] fetch_addr;
    logic              inflight;
    logic              rd_ok, rd_go, hr_int, host_go;
    logic              push, pop, fifo_empty;

    // Level counts the outstanding read so the FIFO can never be overcommitted.
    assign level      = occ + CNT_W'(inflight);
    assign fifo_empty = (occ == '0);
    assign rd_ok      = (level < DEPTH_C) && (fetch_addr < END_ADDR);
    assign push       = inflight;
    assign pop        = de && !fifo_empty;

    always_comb begin
        state_nxt = state;
        rd_go     = 1'b0;
        hr_int    = 1'b0;
        case (state)
            S_IDLE: hr_int = 1'b1;
            S_PREFILL: begin
                rd_go = rd_ok;
                if (level == DEPTH_C || fetch_addr == END_ADDR)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                rd_go = rd_ok && ((occ < LOW_C) || !host_valid);
                if ((rd_go && fetch_addr == LAST_ADDR) || fetch_addr == END_ADDR)
                    state_nxt = S_DONE;
            end
            S_DONE: hr_int = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
        if (frame_start) begin
            rd_go     = 1'b0;
            state_nxt = S_PREFILL;
        end
        if (state == S_RUN)
            hr_int = !rd_go;
    end

    assign host_go    = host_valid && hr_int;
    assign host_ready = hr_int && !rst;
    assign mem_en     = (rd_go || host_go) && !rst;
    assign mem_we     = host_go && !rst;
    assign mem_addr   = rd_go ? fetch_addr : host_addr;
    assign mem_wdata  = host_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push && !frame_start)
            fifo_mem[wr_ptr] <= mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inflight   <= 1'b0;
            fetch_addr <= '0;
            pix_data   <= '0;
            underrun   <= 1'b0;
        end else if (frame_start) begin
            // Returning read data for the old frame is dropped with the FIFO contents.
            occ        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            inflight   <= 1'b0;
            fetch_addr <= '0;
            underrun   <= 1'b0;
        end else begin
            inflight <= rd_go;
            if (rd_go)
                fetch_addr <= fetch_addr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pix_data <= fifo_mem[rd_ptr];
            end else if (de) begin
                pix_data <= '0;
                underrun <= 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    logic [15:0] ucnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ucnt <= '0;
        else if (frame_start)
            ucnt <= '0;
        else if (de && fifo_empty && ucnt != 16'hFFFF)
            ucnt <= ucnt + 1'b1;
    end

    assign underrun_cnt = ucnt;
`endif

endmodule

// File: tb/tb_vga_fetch_arbiter.sv
// Bench for vga_fetch_arbiter: small 8x2 frame, 4-deep FIFO, memory returns its own address.
// A queue-based frame model predicts bus grants, pixels and the underrun flag every cycle.
module tb_vga_fetch_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TOTAL = 16;
    localparam int DEPTH = 4;
    localparam int LOWW = 2;
    localparam int P_IDLE = 0, P_PRE = 1, P_RUN = 2, P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          de = 1'b0;
    logic [DW-1:0] pix_data;
    logic          underrun;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_data = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int checks = 0;
    int failures = 0;

    vga_fetch_arbiter #(
        .ACTIVE_WIDTH (8),
        .ACTIVE_HEIGHT(2),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .FIFO_DEPTH   (DEPTH),
        .LOW_WATER    (LOWW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .de         (de),
        .pix_data   (pix_data),
        .underrun   (underrun),
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // memory[a] = a, one cycle read latency
    always @(posedge clk)
        if (mem_en && !mem_we)
            mem_rdata <= mem_addr;

    // ---------------- reference model ----------------
    int         m_phase;
    logic [7:0] q[$];
    bit         m_inf;
    int         m_inf_addr;
    int         m_fetch;
    logic [7:0] m_pix;
    bit         m_und;
    int         m_ucnt;
    bit         m_rd;
    bit         e_en, e_we, e_hr;
    int         e_addr;

    logic [18:0] o_bus, e_bus;
    logic [8:0]  o_out, e_out;
    bit          o_rd;
    logic [7:0]  o_raddr;

    task automatic model_reset();
        m_phase = P_IDLE;
        q.delete();
        m_inf = 0;
        m_inf_addr = 0;
        m_fetch = 0;
        m_pix = 8'h00;
        m_und = 0;
        m_ucnt = 0;
        m_rd = 0;
    endtask

    task automatic model_comb();
        int  lvl;
        bit  ok;
        lvl = q.size() + int'(m_inf);
        ok = (lvl < DEPTH) && (m_fetch < TOTAL);
        m_rd = 0;
        e_hr = 0;
        case (m_phase)
            P_IDLE: e_hr = 1;
            P_PRE:  m_rd = ok;
            P_RUN:  m_rd = ok && (q.size() < LOWW || !host_valid);
            default: e_hr = 1;
        endcase
        if (frame_start) m_rd = 0;
        if (m_phase == P_RUN) e_hr = !m_rd;
        e_we = host_valid && e_hr;
        e_en = m_rd || e_we;
        e_addr = m_rd ? m_fetch : int'(host_addr);
    endtask

    task automatic model_seq();
        int lvl;
        lvl = q.size() + int'(m_inf);
        if (frame_start) begin
            q.delete();
            m_inf = 0;
            m_fetch = 0;
            m_und = 0;
            m_ucnt = 0;
            m_phase = P_PRE;
            return;
        end
        if (de) begin
            if (q.size() > 0) m_pix = q.pop_front();
            else begin
                m_pix = 8'h00;
                m_und = 1;
                if (m_ucnt < 65535) m_ucnt++;
            end
        end
        if (m_inf) q.push_back(m_inf_addr[7:0]);
        if (m_phase == P_PRE && (lvl == DEPTH || m_fetch == TOTAL)) m_phase = P_RUN;
        else if (m_phase == P_RUN && ((m_rd && m_fetch == TOTAL - 1) || m_fetch == TOTAL)) m_phase = P_DONE;
        m_inf = m_rd;
        m_inf_addr = m_fetch;
        if (m_rd) m_fetch++;
    endtask

    // one clock: sample combinational bus at negedge, registered outputs after posedge
    task automatic step();
        @(negedge clk);
        model_comb();
        o_bus = {mem_en, mem_we, host_ready, mem_en ? mem_addr : 8'h00, mem_we ? mem_wdata : 8'h00};
        e_bus = {e_en, e_we, e_hr, e_en ? e_addr[7:0] : 8'h00, e_we ? host_data : 8'h00};
        o_rd = mem_en && !mem_we;
        o_raddr = mem_addr;
        @(posedge clk);
        model_seq();
        #1;
        o_out = {pix_data, underrun};
        e_out = {m_pix, m_und};
    endtask

    task automatic do_reset();
        frame_start = 0;
        de = 0;
        host_valid = 0;
        #2 rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        host_valid = 1;
        host_addr = 8'h07;
        host_data = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, host_ready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_bus got %b exp 000", {mem_en, mem_we, host_ready});
        end
        checks++;
        if ({pix_data, underrun} !== 9'h000) begin
            failures++;
            $display("FAIL reset_out got %h exp 000", {pix_data, underrun});
        end
        model_reset();
        rst = 0;
        @(posedge clk);
        #1;
        step();
        checks++;
        if (o_bus !== {3'b111, 8'h07, 8'hA5}) begin
            failures++;
            $display("FAIL idle_host_write got %h exp %h", o_bus, {3'b111, 8'h07, 8'hA5});
        end
        checks++;
        if (o_bus !== e_bus) begin
            failures++;
            $display("FAIL reset_model_bus got %h exp %h", o_bus, e_bus);
        end
        host_valid = 0;
    endtask

    task automatic test_prefill();
        frame_start = 1;
        step();
        frame_start = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (o_bus !== e_bus) begin
                failures++;
                $display("FAIL prefill_bus i=%0d got %h exp %h", i, o_bus, e_bus);
            end
            checks++;
            if (i < 4 && !(o_rd && o_raddr == 8'(i) && !o_bus[16])) begin
                failures++;
                $display("FAIL prefill_read i=%0d got rd=%0d addr=%0d exp rd=1 addr=%0d", i, o_rd, o_raddr, i);
            end else if (i == 4 && o_rd) begin
                failures++;
                $display("FAIL prefill_full_read got rd=1 exp rd=0");
            end
        end
        host_valid = 1;
        host_addr = 8'h33;
        host_data = 8'h5C;
        step();
        checks++;
        if (o_bus !== {3'b111, 8'h33, 8'h5C}) begin
            failures++;
            $display("FAIL run_host_grant got %h exp %h", o_bus, {3'b111, 8'h33, 8'h5C});
        end
        host_valid = 0;
    endtask

    task automatic test_display();
        int maxr = -1;
        de = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            if (o_rd) maxr = int'(o_raddr);
            checks++;
            if (o_bus !== e_bus) begin
                failures++;
                $display("FAIL display_bus i=%0d got %h exp %h", i, o_bus, e_bus);
            end
            checks++;
            if (o_out !== {8'(i), 1'b0}) begin
                failures++;
                $display("FAIL display_pix i=%0d got %h exp %h", i, o_out, {8'(i), 1'b0});
            end
        end
        de = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o_rd) begin
                failures++;
                $display("FAIL display_read_after_end got addr=%0d exp no read", o_raddr);
            end
        end
        checks++;
        if (maxr != 15) begin
            failures++;
            $display("FAIL display_last_read got %0d exp 15", maxr);
        end
    endtask

    task automatic test_host_done();
        host_valid = 1;
        host_addr = 8'h07;
        host_data = 8'hA5;
        step();
        checks++;
        if (o_bus !== {3'b111, 8'h07, 8'hA5}) begin
            failures++;
            $display("FAIL done_host_write got %h exp %h", o_bus, {3'b111, 8'h07, 8'hA5});
        end
        host_valid = 0;
    endtask

    task automatic test_underrun();
        de = 1;
        step();
        de = 0;
        checks++;
        if (o_out !== {8'h00, 1'b1}) begin
            failures++;
            $display("FAIL underrun_set got %h exp %h", o_out, {8'h00, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (o_out !== e_out || underrun !== 1'b1) begin
                failures++;
                $display("FAIL underrun_sticky got %h exp %h", o_out, e_out);
            end
        end
`ifdef VGA_FETCH_UNDERRUN_CNT_EN
        checks++;
        if (underrun_cnt !== 16'(m_ucnt) || m_ucnt != 1) begin
            failures++;
            $display("FAIL underrun_cnt got %0d exp 1", underrun_cnt);
        end
`endif
        frame_start = 1;
        step();
        frame_start = 0;
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear got %b exp 0", underrun);
        end
    endtask

    task automatic test_host_contend();
        int nwr = 0, nrd = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (o_bus !== e_bus) begin
                failures++;
                $display("FAIL contend_prefill_bus i=%0d got %h exp %h", i, o_bus, e_bus);
            end
        end
        host_valid = 1;
        for (int i = 0; i < 40; i++) begin
            host_addr = 8'($urandom);
            host_data = 8'($urandom);
            de = 1'($urandom_range(0, 1));
            step();
            if (o_bus[17]) nwr++;
            if (o_rd) nrd++;
            checks++;
            if (o_bus !== e_bus || o_out !== e_out) begin
                failures++;
                $display("FAIL contend i=%0d got bus=%h out=%h exp bus=%h out=%h", i, o_bus, o_out, e_bus, e_out);
            end
        end
        host_valid = 0;
        de = 0;
        checks++;
        if (nwr == 0 || nrd == 0) begin
            failures++;
            $display("FAIL contend_mix got wr=%0d rd=%0d exp both nonzero", nwr, nrd);
        end
    endtask

    task automatic test_squash();
        bit         found = 0;
        logic [7:0] rds[$];
        frame_start = 1;
        step();
        frame_start = 0;
        for (int i = 0; i < 5; i++) step();
        de = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            checks++;
            if (o_bus !== e_bus || o_out !== e_out) begin
                failures++;
                $display("FAIL squash_run i=%0d got bus=%h out=%h exp bus=%h out=%h", i, o_bus, o_out, e_bus, e_out);
            end
            if (o_rd && o_raddr == 8'd5) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL squash_wait got no read of addr 5 exp one within 20 cycles");
        end
        de = 0;
        frame_start = 1;
        step();
        frame_start = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_rd) rds.push_back(o_raddr);
            checks++;
            if (o_bus !== e_bus) begin
                failures++;
                $display("FAIL squash_refill_bus i=%0d got %h exp %h", i, o_bus, e_bus);
            end
        end
        checks++;
        if (rds.size() != 4 || rds[0] != 8'd0 || rds[1] != 8'd1 || rds[2] != 8'd2 || rds[3] != 8'd3) begin
            failures++;
            $display("FAIL squash_reads got n=%0d first=%0d exp 0,1,2,3", rds.size(), rds.size() > 0 ? rds[0] : 8'hFF);
        end
        de = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (o_out !== {8'(i), 1'b0}) begin
                failures++;
                $display("FAIL squash_pix i=%0d got %h exp %h", i, o_out, {8'(i), 1'b0});
            end
        end
        de = 0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 1500; i++) begin
            frame_start = ($urandom_range(0, 49) == 0);
            de = 1'($urandom_range(0, 1));
            host_valid = ($urandom_range(0, 9) < 6);
            host_addr = 8'($urandom);
            host_data = 8'($urandom);
            step();
            checks++;
            if (o_bus !== e_bus || o_out !== e_out) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("FAIL random i=%0d got bus=%h out=%h exp bus=%h out=%h", i, o_bus, o_out, e_bus, e_out);
            end
        end
        frame_start = 0;
        de = 0;
        host_valid = 0;
    endtask

    task automatic test_mid_reset();
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        step();
        do_reset();
        host_valid = 1;
        step();
        checks++;
        if (o_bus !== e_bus || e_hr != 1 || o_out !== 9'h000) begin
            failures++;
            $display("FAIL mid_reset got bus=%h out=%h exp bus=%h out=000", o_bus, o_out, e_bus);
        end
        host_valid = 0;
        frame_start = 1;
        step();
        frame_start = 0;
        step();
        checks++;
        if (!(o_rd && o_raddr == 8'd0) || o_bus !== e_bus) begin
            failures++;
            $display("FAIL mid_reset_refetch got bus=%h exp %h", o_bus, e_bus);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        test_reset();
        test_prefill();
        test_display();
        test_host_done();
        test_underrun();
        test_host_contend();
        test_squash();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
